lsu_mem_master: RTL and testbench

- Load/store initiator that drives the single-port 32-bit data memory on behalf of the RV32I core.
- Accepts LB/LH/LW/LBU/LHU/SB/SH/SW requests from the execute/memory stage through a valid/ready handshake.
- Issues word-aligned memory accesses and returns aligned, sign- or zero-extended load data.
- The memory has only a word write-enable and no byte lanes, so SB/SH are performed as read-modify-write.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_byte_lane.sv | 37 +++
 rtl/lsu_mem_master.sv | 127 ++++++++++++
 tb/tb_lsu_mem_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the load/store unit memory master.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and byte/half store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = load_word[{addr_lo, 3'b000} +: 8];
        lane_h    = load_word[{addr_lo[1], 4'b0000} +: 16];
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'b0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'b0, lane_h};
            default: load_data = load_word;
        endcase

        merged_word = old_word;
        case (funct3)
            F3_B:    merged_word[{addr_lo, 3'b000} +: 8]    = wdata[7:0];
            F3_H:    merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-only memory; sub-word stores use read-modify-write.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT = 3'(READ_LAT);

    lsu_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] word_q, word_d;

    logic        accept;
    logic        rd_done;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign rd_done = (state_q == ST_RD_WAIT) && (cnt_q == LAT);
    assign req_err = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    lsu_byte_lane u_lane (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .load_word   (word_q),
        .old_word    (mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                         state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W) state_d = ST_WR;
                    else                                 state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: if (rd_done) state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // word_q holds the SW data, the merged RMW word, or the raw loaded word.
    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        word_d   = word_q;
        if (accept) begin
            cnt_d    = '0;
            addr_d   = req_addr;
            funct3_d = req_funct3;
            we_d     = req_we;
            wdata_d  = req_wdata;
            err_d    = req_err;
            word_d   = req_wdata;
        end else if (state_q == ST_RD_WAIT) begin
            cnt_d = cnt_q + 3'd1;
            if (rd_done) word_d = we_q ? merged_word : mem_rdata;
        end
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_we     = (state_q == ST_WR);
        resp_valid = (state_q == ST_RESP);
        resp_err   = (state_q == ST_RESP) && err_q;
        resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? load_data : 32'h0;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = word_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a READ_LAT=1 word memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Word memory: untouched words read their initial image, 0x100 = 0x8899AABB.
    logic [31:0]  mem [256];
    logic [255:0] written = '0;

    function automatic logic [31:0] rd_word(input logic [7:0] idx);
        if (written[idx]) return mem[idx];
        return (idx == 8'h40) ? 32'h8899AABB : 32'h0;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= rd_word(mem_addr[9:2]);
        if (mem_we) begin
            mem[mem_addr[9:2]]     <= mem_wdata;
            written[mem_addr[9:2]] <= 1'b1;
        end
    end

    lsu_mem_master #(.READ_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Issues one request starting from a negedge and observes it up to the RESP cycle.
    // Cycle numbers are counted from the accepting edge; -1 means never seen.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int wait_cyc, output int resp_cyc,
                           output int we_cnt, output int we_cyc, output logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output logic [31:0] addr0);
        wait_cyc = 0; resp_cyc = -1; we_cnt = 0; we_cyc = -1;
        wd = '0; rd = '0; err = 1'b0; addr0 = '0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0;
                addr0 = mem_addr;
            end
            if (mem_we) begin
                we_cnt++;
                we_cyc = k;
                wd = mem_wdata;
            end
            if (resp_valid) begin
                resp_cyc = k;
                rd = resp_rdata;
                err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exps [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
        run_req(1'b0, 3'b010, 32'h100, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL lw_data: got %h want 8899aabb", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", err); end
        checks++; if (r !== 2) begin errors++; $display("FAIL lw_resp_cycle: got %0d want 2", r); end
        checks++; if (wn !== 0) begin errors++; $display("FAIL lw_no_write: got %0d writes want 0", wn); end
        checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL lw_mem_addr: got %h want 100", a0); end
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, f3s[i], adrs[i], 32'h0, w, r, wn, wc, wd, rd, err, a0);
            checks++;
            if (rd !== exps[i] || err !== 1'b0 || r !== 2) begin
                errors++;
                $display("FAIL subword_load_%0d: got data %h err %b cycle %0d want %h 0 2", i, rd, err, r, exps[i]);
            end
            checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL subword_addr_%0d: got %h want 100", i, a0); end
        end
    endtask

    task automatic test_sb();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        run_req(1'b1, 3'b000, 32'h101, 32'h12345677, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (wn !== 1) begin errors++; $display("FAIL sb_write_count: got %0d want 1", wn); end
        checks++; if (wc !== 2) begin errors++; $display("FAIL sb_write_cycle: got %0d want 2", wc); end
        checks++; if (wd !== 32'h889977BB) begin errors++; $display("FAIL sb_merge: got %h want 889977bb", wd); end
        checks++; if (r !== 3) begin errors++; $display("FAIL sb_resp_cycle: got %0d want 3", r); end
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sb_resp: got data %h err %b want 0 0", rd, err); end
        checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL sb_mem_addr: got %h want 100", a0); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'h889977BB) begin errors++; $display("FAIL sb_readback: got %h want 889977bb", rd); end
    endtask

    task automatic test_sh_sw();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        run_req(1'b1, 3'b001, 32'h102, 32'h0000CAFE, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (wn !== 1 || wc !== 2 || r !== 3) begin errors++; $display("FAIL sh_timing: got writes %0d wcyc %0d resp %0d want 1 2 3", wn, wc, r); end
        checks++; if (wd !== 32'hCAFE77BB) begin errors++; $display("FAIL sh_merge: got %h want cafe77bb", wd); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'hCAFE77BB) begin errors++; $display("FAIL sh_readback: got %h want cafe77bb", rd); end
        run_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (wn !== 1 || wc !== 0) begin errors++; $display("FAIL sw_write: got writes %0d wcyc %0d want 1 0", wn, wc); end
        checks++; if (r !== 1) begin errors++; $display("FAIL sw_resp_cycle: got %0d want 1", r); end
        checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", wd); end
        checks++; if (a0 !== 32'h104) begin errors++; $display("FAIL sw_mem_addr: got %h want 104", a0); end
        run_req(1'b0, 3'b010, 32'h104, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback: got %h want deadbeef", rd); end
    endtask

    task automatic test_errors();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] adrs [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            run_req(wes[i], f3s[i], adrs[i], 32'h5A5A5A5A, w, r, wn, wc, wd, rd, err, a0);
            checks++;
            if (err !== 1'b1 || rd !== 32'h0 || r !== 0 || wn !== 0) begin
                errors++;
                $display("FAIL error_case_%0d: got err %b data %h resp %0d writes %0d want 1 0 0 0", i, err, rd, r, wn);
            end
        end
        run_req(1'b0, 3'b010, 32'h100, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'hCAFE77BB) begin errors++; $display("FAIL error_mem_unchanged: got %h want cafe77bb", rd); end
    endtask

    task automatic test_back_to_back();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        run_req(1'b0, 3'b010, 32'h104, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 0", req_ready); end
        run_req(1'b0, 3'b101, 32'h102, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (w !== 1) begin errors++; $display("FAIL b2b_accept_wait: got %0d want 1", w); end
        checks++; if (rd !== 32'h0000CAFE || r !== 2) begin errors++; $display("FAIL b2b_second: got %h cycle %0d want 0000cafe 2", rd, r); end
    endtask

    task automatic test_reset_mid();
        int w, r, wn, wc;
        logic [31:0] wd, rd, a0;
        logic err;
        int bad_we = 0;
        int bad_resp = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            if (mem_we) bad_we++;
            if (resp_valid) bad_resp++;
        end
        checks++; if (bad_we !== 0) begin errors++; $display("FAIL rst_mid_no_write: got %0d writes want 0", bad_we); end
        checks++; if (bad_resp !== 0) begin errors++; $display("FAIL rst_mid_no_resp: got %0d responses want 0", bad_resp); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0, w, r, wn, wc, wd, rd, err, a0);
        checks++; if (rd !== 32'hCAFE77BB) begin errors++; $display("FAIL rst_mid_mem: got %h want cafe77bb", rd); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sb();
        test_sh_sw();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
